// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states, result
// encoding and the chunk-count helper used to size the chunk index.
package cmp_pkg;

    typedef enum logic [1:0] {IDLE, COMPARE, DONE} cmp_state_e;

    typedef enum logic [1:0] {RES_NONE, RES_GT, RES_EQ, RES_LT} cmp_res_e;

    function automatic int chunk_count(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the comparator outcome statistics.
// Holds at all-ones instead of wrapping; clears on the asynchronous reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator: walks CHUNK bits per cycle from the MSB and
// stops at the first differing chunk. Define CMP_STATS_EN for outcome counters.
module seq_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             r,
    output logic             g,
    output logic             b
`ifdef CMP_STATS_EN
    ,
    output logic [CNT_W-1:0] gt_count,
    output logic [CNT_W-1:0] eq_count,
    output logic [CNT_W-1:0] lt_count
`endif
);

    localparam int N     = chunk_count(WIDTH, CHUNK);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0 || CNT_W < 1) begin : g_param_check
        $error("seq_mag_comparator: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    cmp_state_e       state_q, state_d;
    cmp_res_e         res_q;
    logic [WIDTH-1:0] sa_q, sb_q;
    logic [IDX_W-1:0] idx_q;
    logic [CHUNK-1:0] top_a, top_b;

    assign top_a = sa_q[WIDTH-1 -: CHUNK];
    assign top_b = sb_q[WIDTH-1 -: CHUNK];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = COMPARE;
            COMPARE: if ((top_a != top_b) || (idx_q == '0)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Flipping the MSB of both operands turns a two's-complement compare into
    // an unsigned one, so the chunk walk below never needs to know the mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_q  <= '0;
            sb_q  <= '0;
            idx_q <= '0;
            res_q <= RES_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sa_q  <= signed_mode ? (op_a ^ MSB_MASK) : op_a;
                        sb_q  <= signed_mode ? (op_b ^ MSB_MASK) : op_b;
                        idx_q <= LAST_IDX;
                    end
                end
                COMPARE: begin
                    if (top_a > top_b) begin
                        res_q <= RES_GT;
                    end else if (top_a < top_b) begin
                        res_q <= RES_LT;
                    end else if (idx_q == '0) begin
                        res_q <= RES_EQ;
                    end else begin
                        sa_q  <= sa_q << CHUNK;
                        sb_q  <= sb_q << CHUNK;
                        idx_q <= idx_q - IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign r         = (res_q == RES_GT);
    assign g         = (res_q == RES_EQ);
    assign b         = (res_q == RES_LT);

`ifdef CMP_STATS_EN
    logic handshake;
    assign handshake = out_valid && out_ready;

    sat_counter #(.CNT_W(CNT_W)) u_gt_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (handshake && (res_q == RES_GT)),
        .count (gt_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_eq_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (handshake && (res_q == RES_EQ)),
        .count (eq_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_lt_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (handshake && (res_q == RES_LT)),
        .count (lt_count)
    );
`endif

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed bench for seq_mag_comparator: an 8-bit/2-bit-chunk instance plus a
// 2-bit/1-bit-chunk instance for the exhaustive small-operand sweep.
module tb_seq_mag_comparator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] op_a = '0;
    logic [7:0] op_b = '0;
    logic       signed_mode = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       r, g, b;

    logic       x_in_valid = 1'b0;
    logic       x_in_ready;
    logic [1:0] x_op_a = '0;
    logic [1:0] x_op_b = '0;
    logic       x_out_valid;
    logic       x_out_ready = 1'b0;
    logic       x_r, x_g, x_b;

`ifdef CMP_STATS_EN
    logic [1:0] gt_count, eq_count, lt_count;
    logic [1:0] x_gt_count, x_eq_count, x_lt_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_mag_comparator #(.WIDTH(8), .CHUNK(2), .CNT_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .r           (r),
        .g           (g),
        .b           (b)
`ifdef CMP_STATS_EN
        ,
        .gt_count    (gt_count),
        .eq_count    (eq_count),
        .lt_count    (lt_count)
`endif
    );

    seq_mag_comparator #(.WIDTH(2), .CHUNK(1), .CNT_W(2)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (x_in_valid),
        .in_ready    (x_in_ready),
        .op_a        (x_op_a),
        .op_b        (x_op_b),
        .signed_mode (1'b0),
        .out_valid   (x_out_valid),
        .out_ready   (x_out_ready),
        .r           (x_r),
        .g           (x_g),
        .b           (x_b)
`ifdef CMP_STATS_EN
        ,
        .gt_count    (x_gt_count),
        .eq_count    (x_eq_count),
        .lt_count    (x_lt_count)
`endif
    );

    task automatic accept_op(input logic [7:0] a, input logic [7:0] bb, input logic s);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        in_valid    = 1'b1;
        op_a        = a;
        op_b        = bb;
        signed_mode = s;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL result_timeout: out_valid=%b required 1", out_valid);
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] bb, input logic s, output int lat);
        accept_op(a, bb, s);
        wait_result(lat);
    endtask

    task automatic take_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int lat;
        checks++;
        if ({r, g, b} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_rgb: got %b required 000", {r, g, b});
        end
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL reset_handshake: got out_valid,in_ready=%b required 01", {out_valid, in_ready});
        end
        run_op(8'hC0, 8'h40, 1'b0, lat);
        take_result();
        accept_op(8'h10, 8'h11, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({r, g, b} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL midreset_rgb: got %b required 000", {r, g, b});
        end
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL midreset_handshake: got out_valid,in_ready=%b required 01", {out_valid, in_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h12, 8'h12, 1'b0, lat);
        checks++;
        if ({r, g, b} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL equal_rgb: got %b required 010", {r, g, b});
        end
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("[TB] FAIL equal_latency: got %0d required 4", lat);
        end
        take_result();
    endtask

    task automatic test_unsigned();
        int lat;
        run_op(8'hC0, 8'h40, 1'b0, lat);
        checks++;
        if ({r, g, b, 8'(lat)} !== {3'b100, 8'd1}) begin
            errors++;
            $display("[TB] FAIL unsigned_gt: got rgb=%b lat=%0d required rgb=100 lat=1", {r, g, b}, lat);
        end
        take_result();
        run_op(8'h41, 8'h42, 1'b0, lat);
        checks++;
        if ({r, g, b, 8'(lat)} !== {3'b001, 8'd4}) begin
            errors++;
            $display("[TB] FAIL unsigned_lt: got rgb=%b lat=%0d required rgb=001 lat=4", {r, g, b}, lat);
        end
        take_result();
    endtask

    task automatic test_signed();
        int lat;
        run_op(8'hFF, 8'h01, 1'b1, lat);
        checks++;
        if ({r, g, b, 8'(lat)} !== {3'b001, 8'd1}) begin
            errors++;
            $display("[TB] FAIL signed_neg1_vs_1: got rgb=%b lat=%0d required rgb=001 lat=1", {r, g, b}, lat);
        end
        take_result();
        run_op(8'hFF, 8'h01, 1'b0, lat);
        checks++;
        if ({r, g, b, 8'(lat)} !== {3'b100, 8'd1}) begin
            errors++;
            $display("[TB] FAIL unsigned_ff_vs_1: got rgb=%b lat=%0d required rgb=100 lat=1", {r, g, b}, lat);
        end
        take_result();
        run_op(8'h80, 8'h7F, 1'b1, lat);
        checks++;
        if ({r, g, b, 8'(lat)} !== {3'b001, 8'd1}) begin
            errors++;
            $display("[TB] FAIL signed_min_vs_max: got rgb=%b lat=%0d required rgb=001 lat=1", {r, g, b}, lat);
        end
        take_result();
        run_op(8'hFE, 8'hFF, 1'b1, lat);
        checks++;
        if ({r, g, b, 8'(lat)} !== {3'b001, 8'd4}) begin
            errors++;
            $display("[TB] FAIL signed_neg2_vs_neg1: got rgb=%b lat=%0d required rgb=001 lat=4", {r, g, b}, lat);
        end
        take_result();
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(8'h20, 8'h10, 1'b0, lat);
        checks++;
        if ({r, g, b, 8'(lat)} !== {3'b100, 8'd2}) begin
            errors++;
            $display("[TB] FAIL bp_result: got rgb=%b lat=%0d required rgb=100 lat=2", {r, g, b}, lat);
        end
        @(negedge clk);
        in_valid = 1'b1;
        op_a     = 8'h00;
        op_b     = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready, r, g, b} !== 5'b10100) begin
                errors++;
                $display("[TB] FAIL bp_hold_%0d: got out_valid,in_ready,rgb=%b required 10100", i, {out_valid, in_ready, r, g, b});
            end
        end
        in_valid = 1'b0;
        take_result();
        checks++;
        if ({out_valid, in_ready, r, g, b} !== 5'b01100) begin
            errors++;
            $display("[TB] FAIL bp_release: got out_valid,in_ready,rgb=%b required 01100", {out_valid, in_ready, r, g, b});
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL bp_ignored_op: got out_valid,in_ready=%b required 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(8'h33, 8'h33, 1'b0, lat);
        checks++;
        if ({r, g, b, 8'(lat)} !== {3'b010, 8'd4}) begin
            errors++;
            $display("[TB] FAIL b2b_first: got rgb=%b lat=%0d required rgb=010 lat=4", {r, g, b}, lat);
        end
        @(negedge clk);
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        op_a        = 8'h00;
        op_b        = 8'h80;
        signed_mode = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready, r, g, b} !== 5'b01010) begin
            errors++;
            $display("[TB] FAIL b2b_result_only: got out_valid,in_ready,rgb=%b required 01010", {out_valid, in_ready, r, g, b});
        end
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_accept: got in_ready=%b required 0", in_ready);
        end
        wait_result(lat);
        checks++;
        if ({r, g, b, 8'(lat)} !== {3'b001, 8'd1}) begin
            errors++;
            $display("[TB] FAIL b2b_second: got rgb=%b lat=%0d required rgb=001 lat=1", {r, g, b}, lat);
        end
        take_result();
    endtask

    task automatic test_exhaustive_2bit();
        logic [1:0] av, bv;
        logic [2:0] exp_rgb;
        int         exp_lat, lat, n;
        for (int a = 0; a < 4; a++) begin
            for (int bb = 0; bb < 4; bb++) begin
                av      = 2'(a);
                bv      = 2'(bb);
                exp_rgb = (a > bb) ? 3'b100 : ((a == bb) ? 3'b010 : 3'b001);
                exp_lat = (av[1] != bv[1]) ? 1 : 2;
                n = 0;
                @(negedge clk);
                while (!x_in_ready && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                x_in_valid = 1'b1;
                x_op_a     = av;
                x_op_b     = bv;
                @(posedge clk);
                #1 x_in_valid = 1'b0;
                lat = 0;
                while (!x_out_valid && lat < 20) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                checks++;
                if ({x_out_valid, x_r, x_g, x_b, 8'(lat)} !== {1'b1, exp_rgb, 8'(exp_lat)}) begin
                    errors++;
                    $display("[TB] FAIL x2_%0d_%0d: got valid=%b rgb=%b lat=%0d required valid=1 rgb=%b lat=%0d",
                             a, bb, x_out_valid, {x_r, x_g, x_b}, lat, exp_rgb, exp_lat);
                end
                @(negedge clk);
                x_out_ready = 1'b1;
                @(posedge clk);
                #1 x_out_ready = 1'b0;
            end
        end
    endtask

`ifdef CMP_STATS_EN
    task automatic test_stats();
        int lat;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_op(8'hC0, 8'h40, 1'b0, lat);
            take_result();
            if (i == 1) begin
                checks++;
                if (gt_count !== 2'd2) begin
                    errors++;
                    $display("[TB] FAIL stats_gt_two: got %0d required 2", gt_count);
                end
            end
        end
        checks++;
        if ({gt_count, eq_count, lt_count} !== {2'd3, 2'd0, 2'd0}) begin
            errors++;
            $display("[TB] FAIL stats_saturate: got gt=%0d eq=%0d lt=%0d required gt=3 eq=0 lt=0",
                     gt_count, eq_count, lt_count);
        end
    endtask
`endif

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_backpressure();
        test_back_to_back();
        test_exhaustive_2bit();
`ifdef CMP_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_mag_comparator.md
Name: seq_mag_comparator

Overview:
- Parametrised, multi-cycle successor to the 2-bit combinational RGB comparator.
- Compares two WIDTH-bit operands, CHUNK bits per cycle, starting at the MSB, and stops early at the first differing chunk.
- Drives registered one-hot r/g/b indicators (greater / equal / less) with valid/ready handshakes on both sides.
- Sits between the operand-capture logic and the LED / result consumer.

Parameters:
- WIDTH, 8, operand width in bits; must be ≥ 2.
- CHUNK, 2, bits compared per cycle; WIDTH % CHUNK == 0 is checked by an elaboration-time assertion.
- CNT_W, 16, width of the statistics counters (used only with CMP_STATS_EN).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept operands (high only in IDLE).
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; sampled at accept.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- r  out  1  A > B.
- g  out  1  A == B.
- b  out  1  A < B.
- gt_count / eq_count / lt_count  out  CNT_W each  outcome counters (CMP_STATS_EN only).

Behaviour:
- Reset: all outputs and state are cleared asynchronously.
  - r = g = b = 0, out_valid = 0, in_ready = 1, state = IDLE, chunk index = 0.
  - Reset mid-compare aborts the operation; the partial result is discarded.
- FSM states: IDLE, COMPARE, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture op_a and op_b into shift registers. When signed_mode = 1, invert the MSB of both copies; this maps signed order onto unsigned order.
  - Chunk index = N−1, where N = WIDTH/CHUNK. Go to COMPARE.
- COMPARE (in_ready = 0):
  - Compare the top CHUNK bits of sa and sb.
  - sa_top > sb_top: set r=1, g=0, b=0; go to DONE.
  - sa_top < sb_top: set b=1, r=0, g=0; go to DONE.
  - Equal and index == 0: set g=1, r=0, b=0; go to DONE.
  - Equal and index > 0: shift both registers left by CHUNK, decrement the index, stay in COMPARE.
- DONE:
  - out_valid = 1.
  - On out_ready: clear out_valid and return to IDLE. The earliest new accept is the following cycle, so there is no overlap.
  - out_ready while in IDLE or COMPARE is ignored.
- Latency: out_valid rises k cycles after the accept edge, where k is the deciding chunk index counted from the MSB.
  - Minimum k = 1 (MSB chunk differs); maximum k = N (operands equal or differ only in the LSB chunk).
- Indicator hold:
  - r/g/b change only on the COMPARE→DONE transition and hold their last result through IDLE and the next COMPARE.
  - Exactly one of r/g/b is high after the first result; none are high before it.
- in_valid while in_ready = 0: ignored. The source must hold its operands.
- Simultaneous out_ready and in_valid in DONE: only the result handshake is taken. The operand accept happens one cycle later in IDLE.

Optional Feature:
- Macro: CMP_STATS_EN.
- Defined:
  - gt_count, eq_count and lt_count ports exist.
  - The matching counter increments by 1 on each out_valid & out_ready handshake, according to the result.
  - Counters saturate at 2^CNT_W − 1 and clear on rst.
- Undefined: the counter ports and logic are absent. The core behaviour is identical either way.

Decomposition:
- Package cmp_pkg:
  - typedef enum logic [1:0] {IDLE, COMPARE, DONE} cmp_state_e;
  - typedef enum logic [1:0] {RES_NONE, RES_GT, RES_EQ, RES_LT} cmp_res_e;
  - function chunk_count(WIDTH, CHUNK).
- One sub-module, sat_counter (parameter CNT_W; ports clk, rst, inc, count), instantiated three times under CMP_STATS_EN.

Test Plan:
- WIDTH=8, CHUNK=2: reset asserted mid-COMPARE (op_a=0x10, op_b=0x11) -> r=g=b=0, out_valid=0, in_ready=1 immediately. After release, op_a=0x12, op_b=0x12 -> g=1, out_valid after 4 cycles.
- Unsigned, op_a=0xC0, op_b=0x40 -> r=1 with latency 1. Then op_a=0x41, op_b=0x42 -> b=1 with latency 4.
- Signed, op_a=0xFF (−1), op_b=0x01 -> b=1. Same pair with signed_mode=0 -> r=1.
- Backpressure: hold out_ready=0 for 5 cycles -> out_valid and r/g/b stable, in_ready=0. Driving in_valid during this time is ignored.
- Exhaustive 2-bit regression, WIDTH=2, CHUNK=1: all 16 A/B pairs -> r/g/b matches the golden compare, with latency ≤ 2.
- CMP_STATS_EN, CNT_W=2: 5 GT results -> gt_count saturates at 3; eq_count = lt_count = 0.
